alu_seq: RTL and testbench

Parametrised sequential ALU for the pipelined MIPS datapath: extends the single-cycle ALU op set (AND/OR/ADD/SUB/SLT) with NOR and iterative signed/unsigned multiply and divide writing HI/LO. Operations are launched with a start/done handshake. The EX stage stalls on `busy`. Single-cycle ops return in one clock; mul/div take WIDTH+1 clocks.

---
 rtl/alu_seq.sv | 202 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential MIPS ALU: single-cycle logic/arith ops plus iterative
// signed/unsigned multiply and divide writing HI/LO, start/done handshake.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic               div_ok;
  logic [WIDTH-1:0]   step_acc, step_sh;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               accept, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;

  always_comb begin
    alu_res = '0;
    case (control)
      4'b0000: alu_res = in1 & in2;
      4'b0001: alu_res = in1 | in2;
      4'b0010: alu_res = in1 + in2;
      4'b0110: alu_res = in1 - in2;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      4'b1100: alu_res = ~(in1 | in2);
      default: alu_res = '0;
    endcase
  end

  // acc holds the running high product / partial remainder, sh the low
  // product bits (multiplier) / quotient bits (dividend), opnd the fixed operand.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_trial[WIDTH];
    if (is_div_q) begin
      step_acc = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_sh  = {sh_q[WIDTH-2:0], div_ok};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
    prod     = {step_acc, step_sh};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -step_sh : step_sh;
    rem_fix  = rneg_q ? -step_acc : step_acc;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sh_d       = sh_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    out_d      = out_q;
    zero_d     = zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;

    accept = start && (state_q != S_RUN);
    a_neg  = control[0] & in1[WIDTH-1];
    b_neg  = control[0] & in2[WIDTH-1];
    mag_a  = a_neg ? -in1 : in1;
    mag_b  = b_neg ? -in2 : in2;

    case (state_q)
      S_RUN: begin
        if (dz_q) begin
          hi_d       = acc_q;
          lo_d       = '1;
          div_zero_d = 1'b1;
          state_d    = S_FINISH;
        end else if (cnt_q == CW'(1)) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          cnt_d   = '0;
          state_d = S_FINISH;
        end else begin
          acc_d = step_acc;
          sh_d  = step_sh;
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Accept overrides the FINISH->IDLE default so back-to-back ops chain.
    if (accept) begin
      if (control[3:2] == 2'b10) begin
        is_div_d = control[1];
        neg_d    = a_neg ^ b_neg;
        rneg_d   = a_neg;
        cnt_d    = CW'(WIDTH);
        state_d  = S_RUN;
        if (control[1]) begin
          dz_d   = (in2 == '0);
          acc_d  = (in2 == '0) ? in1 : '0;
          sh_d   = mag_a;
          opnd_d = mag_b;
        end else begin
          dz_d   = 1'b0;
          acc_d  = '0;
          sh_d   = mag_b;
          opnd_d = mag_a;
        end
      end else begin
        out_d   = alu_res;
        zero_d  = (alu_res == '0);
        state_d = S_FINISH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      sh_q       <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      out_q      <= '0;
      zero_q     <= 1'b1;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      sh_q       <= sh_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      out_q      <= out_d;
      zero_q     <= zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_FINISH);
  assign out      = out_q;
  assign zero     = zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  control;
  logic [31:0] in1, in2;
  logic        busy, done, zero, div_zero;
  logic [31:0] out_w, hi, lo;

  logic        start8;
  logic [3:0]  ctl8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, zero8, dz8;
  logic [7:0]  out8, hi8, lo8;

  int n_cmp = 0;
  int n_err = 0;
  int lat;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .control(control),
    .in1(in1), .in2(in2), .busy(busy), .done(done), .out(out_w),
    .zero(zero), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .control(ctl8),
    .in1(a8), .in2(b8), .busy(busy8), .done(done8), .out(out8),
    .zero(zero8), .hi(hi8), .lo(lo8), .div_zero(dz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one op on the 32-bit DUT and wait (bounded) for done.
  // Inputs are scrambled right after accept; poke>0 pulses start at that latency.
  task automatic go(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                    input int poke, output int l);
    logic ov;
    control = c; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; control = 4'b1111; in1 = 32'hDEAD_BEEF; in2 = 32'h0;
    l = 1; ov = 1'b0;
    while (!done && l < 100) begin
      if (busy && done) ov = 1'b1;
      if (l == poke) begin start = 1'b1; control = 4'b0010; end
      else start = 1'b0;
      @(posedge clk); #1;
      l++;
    end
    start = 1'b0;
    if (busy && done) ov = 1'b1;
    check("busy_done_excl", {63'd0, ov}, 64'd0);
  endtask

  task automatic go8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                     output int l);
    ctl8 = c; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; ctl8 = 4'b1111; a8 = 8'h5A; b8 = 8'h00;
    l = 1;
    while (!done8 && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; control = '0; in1 = '0; in2 = '0;
    start8 = 1'b0; ctl8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out", out_w, 0);
    check("rst_zero", zero, 1);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);

    go(4'b0000, 21, 12, 0, lat); check("and", out_w, 4);  check("and_lat", lat, 1);
    go(4'b0001, 21, 12, 0, lat); check("or", out_w, 29);  check("or_lat", lat, 1);
    go(4'b0010, 21, 12, 0, lat); check("add", out_w, 33); check("add_zero", zero, 0);
    go(4'b0111, 21, 12, 0, lat); check("slt", out_w, 0);  check("slt_lat", lat, 1);
    go(4'b0110, 12, 12, 0, lat); check("sub", out_w, 0);  check("sub_zero", zero, 1);
    check("sub_lat", lat, 1);
    go(4'b0111, 32'hFFFF_FFFF, 1, 0, lat); check("slt_signed", out_w, 1);
    go(4'b1100, 0, 0, 0, lat); check("nor", out_w, 32'hFFFF_FFFF);
    check("single_keeps_hi", hi, 0);
    go(4'b0011, 21, 12, 0, lat); check("undef_op", out_w, 0); check("undef_lat", lat, 1);
    go(4'b1100, 0, 0, 0, lat);

    go(4'b1001, 32'hFFFF_FFFD, 7, 5, lat);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    check("mult_lat", lat, 33);
    check("mult_keeps_out", out_w, 32'hFFFF_FFFF);
    go(4'b1000, 32'hFFFF_FFFF, 2, 0, lat);
    check("multu_hi", hi, 1);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    go(4'b1011, 32'hFFFF_FFF9, 2, 0, lat);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lat", lat, 33);
    check("div_dz", div_zero, 0);
    go(4'b1010, 5, 0, 0, lat);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 5);
    check("divz_flag", div_zero, 1);
    check("divz_lat", lat, 2);
    go(4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 0);
    check("divovf_dz", div_zero, 0);

    // Reset 10 cycles into a MULT aborts it.
    control = 4'b1001; in1 = 5; in2 = 6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_out", out_w, 0);
    lat = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    check("abort_no_done", lat, 0);

    reset = 1'b1; start = 1'b1; control = 4'b0010; in1 = 3; in2 = 4;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    check("rst_wins_out", out_w, 0);
    check("rst_wins_done", done, 0);
    go(4'b0010, 1, 1, 0, lat); check("add_after_rst", out_w, 2);

    go8(4'b1001, 8'h80, 8'h80, lat);
    check("w8_mult_hi", hi8, 8'h40);
    check("w8_mult_lo", lo8, 8'h00);
    check("w8_mult_lat", lat, 9);
    go8(4'b1010, 200, 7, lat);
    check("w8_divu1_lo", lo8, 28);
    check("w8_divu1_hi", hi8, 4);
    go8(4'b1010, 100, 9, lat);
    check("w8_divu2_lo", lo8, 11);
    check("w8_divu2_hi", hi8, 1);
    check("w8_b2b_lat", lat, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
